// File: rtl/turn_scheduler.sv
// rtl/turn_scheduler.sv - two-tank artillery turn, fire, flight and score sequencer
module turn_scheduler #(
   parameter int TURN_FRAMES   = 600,
   parameter int FLIGHT_FRAMES = 300,
   parameter int WIN_SCORE     = 5
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       vs,
   input  logic [7:0] keycode,
   input  logic       hit1,
   input  logic       hit2,
   input  logic       shell_done,
   output logic [7:0] keycode1,
   output logic [7:0] keycode2,
   output logic       fire,
   output logic       active_player,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic [9:0] turn_frames_left,
   output logic       game_over,
   output logic       winner,
   output logic [2:0] state
);

   localparam logic [7:0] KEY_ENTER   = 8'h28;
   localparam logic [7:0] KEY_SPACE   = 8'h2C;
   localparam logic [9:0] TURN_INIT   = 10'(TURN_FRAMES);
   localparam logic [9:0] FLIGHT_INIT = 10'(FLIGHT_FRAMES);
   localparam logic [3:0] WIN         = 4'(WIN_SCORE);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_AIM      = 3'd1,
      S_FIRE     = 3'd2,
      S_FLIGHT   = 3'd3,
      S_SCORE    = 3'd4,
      S_SWAP     = 3'd5,
      S_GAMEOVER = 3'd6
   } state_t;

   state_t     st;
   logic       vs_q1, vs_q2;
   logic [7:0] key_q;
   logic [9:0] flight_cnt;
   logic       lat_opp, lat_self;

   logic       tick, enter_press, space_press, aim_expire;
   logic       opp_now, self_now;
   logic [3:0] score1_next, score2_next;

   assign state = st;

   function automatic logic [3:0] sat_inc(input logic [3:0] s);
      return (s < WIN) ? s + 4'd1 : s;
   endfunction

   // Frame tick, key edge detection, hit decoding relative to the shooter, and next scores
   always_comb begin
      tick        = vs_q1 & ~vs_q2;
      enter_press = (keycode == KEY_ENTER) && (key_q != KEY_ENTER);
      space_press = (keycode == KEY_SPACE) && (key_q != KEY_SPACE);
      aim_expire  = tick && (turn_frames_left <= 10'd1);
      opp_now     = active_player ? hit1 : hit2;
      self_now    = active_player ? hit2 : hit1;
      score1_next = score1;
      score2_next = score2;
      // An opponent hit always wins over a simultaneous self hit
      if (lat_opp) begin
         if (active_player) score2_next = sat_inc(score2);
         else               score1_next = sat_inc(score1);
      end else if (lat_self) begin
         if (active_player) score1_next = sat_inc(score1);
         else               score2_next = sat_inc(score2);
      end
   end

   // Input history registers for vs edge and key edge detection
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_q1 <= 1'b0;
         vs_q2 <= 1'b0;
         key_q <= 8'h00;
      end else begin
         vs_q1 <= vs;
         vs_q2 <= vs_q1;
         key_q <= keycode;
      end
   end

   // Game flow FSM; keycodes are routed only when the next state is AIM
   always_ff @(posedge Clk) begin
      if (Reset) begin
         st               <= S_IDLE;
         active_player    <= 1'b0;
         score1           <= 4'd0;
         score2           <= 4'd0;
         fire             <= 1'b0;
         game_over        <= 1'b0;
         winner           <= 1'b0;
         keycode1         <= 8'h00;
         keycode2         <= 8'h00;
         turn_frames_left <= TURN_INIT;
         flight_cnt       <= FLIGHT_INIT;
         lat_opp          <= 1'b0;
         lat_self         <= 1'b0;
      end else begin
         fire     <= 1'b0;
         keycode1 <= 8'h00;
         keycode2 <= 8'h00;
         case (st)
            S_IDLE: begin
               if (enter_press) begin
                  st               <= S_AIM;
                  score1           <= 4'd0;
                  score2           <= 4'd0;
                  active_player    <= 1'b0;
                  turn_frames_left <= TURN_INIT;
                  keycode1         <= keycode;
               end
            end
            S_AIM: begin
               // Space wins a tie against the expiring tick
               if (space_press) begin
                  st   <= S_FIRE;
                  fire <= 1'b1;
               end else if (aim_expire) begin
                  turn_frames_left <= 10'd0;
                  st               <= S_SWAP;
               end else begin
                  if (tick) turn_frames_left <= turn_frames_left - 10'd1;
                  if (active_player) keycode2 <= keycode;
                  else               keycode1 <= keycode;
               end
            end
            S_FIRE: begin
               st         <= S_FLIGHT;
               flight_cnt <= FLIGHT_INIT;
            end
            S_FLIGHT: begin
               if (hit1 || hit2 || shell_done) begin
                  lat_opp  <= opp_now;
                  lat_self <= self_now;
                  st       <= S_SCORE;
               end else if (tick) begin
                  if (flight_cnt <= 10'd1) begin
                     flight_cnt <= 10'd0;
                     lat_opp    <= 1'b0;
                     lat_self   <= 1'b0;
                     st         <= S_SCORE;
                  end else begin
                     flight_cnt <= flight_cnt - 10'd1;
                  end
               end
            end
            S_SCORE: begin
               score1 <= score1_next;
               score2 <= score2_next;
               if (score1_next == WIN || score2_next == WIN) begin
                  st        <= S_GAMEOVER;
                  game_over <= 1'b1;
                  winner    <= (score1_next != WIN);
               end else begin
                  st <= S_SWAP;
               end
            end
            S_SWAP: begin
               active_player    <= ~active_player;
               st               <= S_AIM;
               turn_frames_left <= TURN_INIT;
               if (active_player) keycode1 <= keycode;
               else               keycode2 <= keycode;
            end
            S_GAMEOVER: begin
               if (enter_press) begin
                  st        <= S_IDLE;
                  game_over <= 1'b0;
                  winner    <= 1'b0;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_turn_scheduler.sv
// tb/tb_turn_scheduler.sv - self-checking bench for turn_scheduler
module tb_turn_scheduler;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       vs = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic       hit1 = 1'b0, hit2 = 1'b0, shell_done = 1'b0;
   logic [7:0] keycode1, keycode2;
   logic       fire, active_player, game_over, winner;
   logic [3:0] score1, score2;
   logic [9:0] turn_frames_left;
   logic [2:0] state;

   int n_pass = 0;
   int n_total = 0;

   turn_scheduler dut (
      .Clk(Clk), .Reset(Reset), .vs(vs), .keycode(keycode),
      .hit1(hit1), .hit2(hit2), .shell_done(shell_done),
      .keycode1(keycode1), .keycode2(keycode2), .fire(fire),
      .active_player(active_player), .score1(score1), .score2(score2),
      .turn_frames_left(turn_frames_left), .game_over(game_over),
      .winner(winner), .state(state)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       h1, h2, d;
      logic [3:0] s1, s2;
      logic       ap, go, win;
   } vec_t;

   vec_t tbl [10];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic do_tick();
      vs = 1'b1;
      step();
      vs = 1'b0;
      step();
   endtask

   task automatic press(input logic [7:0] k);
      keycode = k;
      step();
      keycode = 8'h00;
      step();
   endtask

   task automatic chk_reset(input string tag);
      check({tag, " state"}, int'(state), 0);
      check({tag, " active_player"}, int'(active_player), 0);
      check({tag, " score1"}, int'(score1), 0);
      check({tag, " score2"}, int'(score2), 0);
      check({tag, " fire"}, int'(fire), 0);
      check({tag, " game_over"}, int'(game_over), 0);
      check({tag, " winner"}, int'(winner), 0);
      check({tag, " keycode1"}, int'(keycode1), 0);
      check({tag, " keycode2"}, int'(keycode2), 0);
      check({tag, " turn_frames_left"}, int'(turn_frames_left), 600);
   endtask

   // From AIM: fire, raise the flags for one FLIGHT cycle after a delay, run to the next AIM
   task automatic play_turn(input logic h1, input logic h2, input logic d, input int delay);
      keycode = 8'h2C;
      step();
      keycode = 8'h00;
      step();
      for (int i = 0; i < delay; i++) step();
      hit1 = h1; hit2 = h2; shell_done = d;
      step();
      hit1 = 1'b0; hit2 = 1'b0; shell_done = 1'b0;
      step();
      step();
   endtask

   initial begin
      int fires;
      int m_s [2];
      int m_ap, m_win, opp, slf, n, k;
      bit m_over;
      logic rh1, rh2, rd;

      tbl[0] = '{1'b0, 1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 1'b0, 4'd3, 4'd2, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 1'b1, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0};
      tbl[9] = '{1'b1, 1'b0, 1'b0, 4'd4, 4'd5, 1'b1, 1'b1, 1'b1};

      step(); step();
      chk_reset("reset");
      Reset = 1'b0;
      step();

      // Enter starts the game; keys route to tank 1 one cycle later
      keycode = 8'h28;
      step();
      check("enter state", int'(state), 1);
      check("enter active_player", int'(active_player), 0);
      keycode = 8'h1A;
      step();
      check("route keycode1", int'(keycode1), 'h1A);
      check("route keycode2", int'(keycode2), 0);
      keycode = 8'h00;
      step();

      // Hits outside FLIGHT are ignored
      hit2 = 1'b1;
      step();
      hit2 = 1'b0;
      step();
      check("aim hit ignored state", int'(state), 1);
      check("aim hit ignored score1", int'(score1), 0);

      // Held Space fires once
      keycode = 8'h2C;
      fires = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (fire) fires++;
      end
      check("held space fire count", fires, 1);
      check("held space state", int'(state), 3);
      keycode = 8'h00;
      hit2 = 1'b1;
      step();
      hit2 = 1'b0;
      check("hit2 -> score state", int'(state), 4);
      step();
      check("hit2 score1", int'(score1), 1);
      check("hit2 -> swap state", int'(state), 5);
      step();
      check("after swap state", int'(state), 1);
      check("after swap active_player", int'(active_player), 1);

      // Aim timeout forfeits the turn
      for (int i = 0; i < 599; i++) do_tick();
      check("aim 599 ticks frames_left", int'(turn_frames_left), 1);
      check("aim 599 ticks state", int'(state), 1);
      do_tick();
      check("aim timeout state", int'(state), 5);
      check("aim timeout frames_left", int'(turn_frames_left), 0);
      step();
      check("aim timeout active_player", int'(active_player), 0);
      check("aim reload frames_left", int'(turn_frames_left), 600);
      check("aim timeout score1", int'(score1), 1);
      check("aim timeout score2", int'(score2), 0);

      // Space and the final tick together resolve to FIRE
      for (int i = 0; i < 599; i++) do_tick();
      vs = 1'b1;
      step();
      vs = 1'b0;
      keycode = 8'h2C;
      step();
      check("tie state", int'(state), 2);
      check("tie fire", int'(fire), 1);
      keycode = 8'h00;
      step();
      check("tie -> flight", int'(state), 3);

      // Flight timeout scores nothing
      for (int i = 0; i < 299; i++) do_tick();
      check("flight 299 ticks state", int'(state), 3);
      do_tick();
      check("flight timeout state", int'(state), 4);
      step();
      check("flight timeout swap", int'(state), 5);
      check("flight timeout score1", int'(score1), 1);
      check("flight timeout score2", int'(score2), 0);
      step();
      check("flight timeout active_player", int'(active_player), 1);

      // Reset in FLIGHT
      keycode = 8'h2C;
      step();
      keycode = 8'h00;
      step();
      Reset = 1'b1;
      step();
      chk_reset("reset in flight");
      Reset = 1'b0;
      step();

      // Reset in the same cycle as a Space press
      press(8'h28);
      keycode = 8'h2C;
      Reset = 1'b1;
      step();
      check("reset+space fire", int'(fire), 0);
      check("reset+space state", int'(state), 0);
      Reset = 1'b0;
      keycode = 8'h00;
      step();

      // Scoring rules table, ending in a player 2 win
      press(8'h28);
      for (int i = 0; i < 10; i++) begin
         play_turn(tbl[i].h1, tbl[i].h2, tbl[i].d, 0);
         check($sformatf("tbl%0d score1", i), int'(score1), int'(tbl[i].s1));
         check($sformatf("tbl%0d score2", i), int'(score2), int'(tbl[i].s2));
         check($sformatf("tbl%0d active_player", i), int'(active_player), int'(tbl[i].ap));
         check($sformatf("tbl%0d game_over", i), int'(game_over), int'(tbl[i].go));
         check($sformatf("tbl%0d state", i), int'(state), tbl[i].go ? 6 : 1);
         if (tbl[i].go) check($sformatf("tbl%0d winner", i), int'(winner), int'(tbl[i].win));
      end
      press(8'h28);
      check("gameover enter state", int'(state), 0);
      check("idle holds score2", int'(score2), 5);
      press(8'h28);
      check("restart score1", int'(score1), 0);
      check("restart score2", int'(score2), 0);

      // Player 1 lands five hits
      for (int i = 0; i < 5; i++) begin
         play_turn(1'b0, 1'b1, 1'b0, 1);
         if (i < 4) play_turn(1'b0, 1'b0, 1'b1, 1);
      end
      check("p0 win state", int'(state), 6);
      check("p0 win game_over", int'(game_over), 1);
      check("p0 win winner", int'(winner), 0);
      check("p0 win score1", int'(score1), 5);
      press(8'h28);
      check("p0 win enter idle", int'(state), 0);
      check("p0 win idle game_over", int'(game_over), 0);
      press(8'h28);
      check("second enter score1", int'(score1), 0);

      // Random turns against a turn-level scoring model
      m_s[0] = 0; m_s[1] = 0; m_ap = 0; m_over = 1'b0; m_win = 0;
      for (int t = 0; t < 80; t++) begin
         if (m_over) begin
            press(8'h28);
            press(8'h28);
            m_s[0] = 0; m_s[1] = 0; m_ap = 0; m_over = 1'b0;
            check("rand restart state", int'(state), 1);
         end
         n = int'($urandom_range(0, 3));
         for (int j = 0; j < n; j++) begin
            k = int'($urandom_range(1, 255));
            if (k == 'h2C) k = 'h1B;
            keycode = 8'(k);
            step();
            check("rand route keycode1", int'(keycode1), (m_ap == 0) ? k : 0);
            check("rand route keycode2", int'(keycode2), (m_ap == 1) ? k : 0);
         end
         rh1 = 1'($urandom_range(0, 1));
         rh2 = 1'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         if (!rh1 && !rh2) rd = 1'b1;
         play_turn(rh1, rh2, rd, int'($urandom_range(0, 5)));
         opp = (m_ap == 0) ? int'(rh2) : int'(rh1);
         slf = (m_ap == 0) ? int'(rh1) : int'(rh2);
         if (opp != 0) m_s[m_ap] = m_s[m_ap] + 1;
         else if (slf != 0) m_s[1 - m_ap] = m_s[1 - m_ap] + 1;
         if (m_s[0] == 5 || m_s[1] == 5) begin
            m_over = 1'b1;
            m_win = (m_s[1] == 5) ? 1 : 0;
         end else begin
            m_ap = 1 - m_ap;
         end
         check("rand score1", int'(score1), m_s[0]);
         check("rand score2", int'(score2), m_s[1]);
         check("rand game_over", int'(game_over), int'(m_over));
         if (m_over) begin
            check("rand winner", int'(winner), m_win);
            check("rand gameover state", int'(state), 6);
         end else begin
            check("rand active_player", int'(active_player), m_ap);
            check("rand aim state", int'(state), 1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
